cache_ctrl: RTL and testbench

Controller FSM for the 4-way set-associative CPU data cache: it accepts one CPU load/store at a time and sequences the `cache_tag` memory and the data array through lookup, dirty write-back, line refill and tag update. It owns the per-set round-robin victim pointers and the handshake to the next memory level. It sits between the CPU load/store path and the tag/data arrays plus the memory/bus interface.

---
 rtl/cache_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: controller for a 4-way set-associative data cache.
// Accepts one CPU load/store at a time. It sequences the tag array and the data
// array through lookup, dirty write-back, line refill and tag update. It also owns
// the per-set round-robin victim pointers.
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   cpu_req_*_i / cpu_req_ready_o, cpu_res_valid_o   CPU handshake
//   tag_req_o, tag_write_o, tag_addr_o, tag_way_o    tag array control
//   tag_read_i, tag_way_i, tag_full_i                tag array lookup result
//   data_we_o, data_way_o                            data array control
//   mem_req_valid_o, mem_req_rw_o, mem_req_addr_o, mem_ready_i   next-level memory
// Control outputs decode the current state and the lookup result, so they
// respond within the cycle. Addresses come straight from flops.

package cache_ctrl_pkg;
  localparam int unsigned TAGMSB    = 31;
  localparam int unsigned TAGLSB    = 14;
  localparam int unsigned INDEX     = 10;
  localparam int unsigned DEPTH     = 1024;
  localparam int unsigned WAYS      = 4;
  localparam int unsigned INDEX_WAY = 2;
  localparam int unsigned OFFW      = 4;
  localparam int unsigned AW        = 32;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TAGMSB:TAGLSB] tag;
  } cache_tag_type;

  typedef struct packed {
    logic [INDEX-1:0] index;
    logic             we;
  } cache_req_type;
endpackage

module cache_ctrl
  import cache_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cpu_req_valid_i,
  input  logic                 cpu_req_rw_i,
  input  logic [AW-1:0]        cpu_req_addr_i,
  output logic                 cpu_req_ready_o,
  output logic                 cpu_res_valid_o,
  output cache_req_type        tag_req_o,
  output cache_tag_type        tag_write_o,
  output logic [TAGMSB:0]      tag_addr_o,
  output logic [INDEX_WAY-1:0] tag_way_o,
  input  cache_tag_type        tag_read_i,
  input  logic [INDEX_WAY-1:0] tag_way_i,
  input  logic                 tag_full_i,
  output logic                 data_we_o,
  output logic [INDEX_WAY-1:0] data_way_o,
  output logic                 mem_req_valid_o,
  output logic                 mem_req_rw_o,
  output logic [AW-1:0]        mem_req_addr_o,
  input  logic                 mem_ready_i
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPARE    = 2'd1,
    WRITE_BACK = 2'd2,
    ALLOCATE   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [TAGMSB:0]      addr_q, addr_d;
  logic                 rw_q, rw_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [INDEX_WAY-1:0] victim_q [DEPTH];
  logic [INDEX_WAY-1:0] victim_d [DEPTH];
  logic                 victim_inc;

  logic [INDEX-1:0]     idx;
  logic [TAGMSB:TAGLSB] req_tag;
  logic [INDEX_WAY-1:0] victim_way;
  logic                 hit;
  logic [AW-1:0]        refill_addr;

  // Occupancy is informational only; nothing in the control path depends on it.
  logic                 unused_tag_full;
  assign unused_tag_full = tag_full_i;

  assign idx         = addr_q[TAGLSB-1:OFFW];
  assign req_tag     = addr_q[TAGMSB:TAGLSB];
  assign victim_way  = victim_q[idx];
  assign hit         = tag_read_i.valid && (tag_read_i.tag == req_tag);
  assign refill_addr = {req_tag, idx, OFFW'(0)};

  assign tag_addr_o     = addr_q;
  assign mem_req_addr_o = mem_addr_q;

  // State, request latch and memory address registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Victim pointers advance only when a line is refilled into the set.
  always_comb begin
    victim_d = victim_q;
    if (victim_inc) begin
      victim_d[idx] = victim_way + INDEX_WAY'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        victim_q[i] <= '0;
      end
    end else begin
      victim_q <= victim_d;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rw_d            = rw_q;
    mem_addr_d      = mem_addr_q;
    victim_inc      = 1'b0;
    cpu_req_ready_o = 1'b0;
    cpu_res_valid_o = 1'b0;
    tag_req_o.index = idx;
    tag_req_o.we    = 1'b0;
    tag_write_o     = '0;
    tag_way_o       = victim_way;
    data_we_o       = 1'b0;
    data_way_o      = '0;
    mem_req_valid_o = 1'b0;
    mem_req_rw_o    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cpu_req_ready_o = 1'b1;
        if (cpu_req_valid_i) begin
          addr_d  = cpu_req_addr_i[TAGMSB:0];
          rw_d    = cpu_req_rw_i;
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        if (hit) begin
          cpu_res_valid_o = 1'b1;
          data_way_o      = tag_way_i;
          if (rw_q) begin
            tag_req_o.we = 1'b1;
            tag_write_o  = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
            data_we_o    = 1'b1;
          end
          state_d = IDLE;
        end else if (tag_read_i.valid && tag_read_i.dirty) begin
          // On a miss the array presents the victim entry, so its tag names the line to evict.
          mem_addr_d = {tag_read_i.tag, idx, OFFW'(0)};
          state_d    = WRITE_BACK;
        end else begin
          mem_addr_d = refill_addr;
          state_d    = ALLOCATE;
        end
      end

      WRITE_BACK: begin
        mem_req_valid_o = 1'b1;
        mem_req_rw_o    = 1'b1;
        if (mem_ready_i) begin
          mem_addr_d = refill_addr;
          state_d    = ALLOCATE;
        end
      end

      ALLOCATE: begin
        mem_req_valid_o = 1'b1;
        if (mem_ready_i) begin
          tag_req_o.we = 1'b1;
          tag_write_o  = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
          data_we_o    = 1'b1;
          data_way_o   = victim_way;
          victim_inc   = 1'b1;
          // The array returns old data during a write, so the hit is resolved by a fresh compare.
          state_d      = COMPARE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed bench for cache_ctrl with a behavioural 4-way tag array.
module tb_cache_ctrl;
  import cache_ctrl_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 cpu_req_valid;
  logic                 cpu_req_rw;
  logic [31:0]          cpu_req_addr;
  logic                 cpu_req_ready_o;
  logic                 cpu_res_valid_o;
  cache_req_type        tag_req_o;
  cache_tag_type        tag_write_o;
  logic [TAGMSB:0]      tag_addr_o;
  logic [INDEX_WAY-1:0] tag_way_o;
  cache_tag_type        tag_read_i;
  logic [INDEX_WAY-1:0] tag_way_i;
  logic                 tag_full_i;
  logic                 data_we_o;
  logic [INDEX_WAY-1:0] data_way_o;
  logic                 mem_req_valid_o;
  logic                 mem_req_rw_o;
  logic [31:0]          mem_req_addr_o;
  logic                 mem_ready;

  int checks = 0;
  int errors = 0;

  cache_tag_type tag_mem [WAYS][DEPTH] = '{default: '0};

  cache_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .cpu_req_valid_i (cpu_req_valid),
    .cpu_req_rw_i    (cpu_req_rw),
    .cpu_req_addr_i  (cpu_req_addr),
    .cpu_req_ready_o (cpu_req_ready_o),
    .cpu_res_valid_o (cpu_res_valid_o),
    .tag_req_o       (tag_req_o),
    .tag_write_o     (tag_write_o),
    .tag_addr_o      (tag_addr_o),
    .tag_way_o       (tag_way_o),
    .tag_read_i      (tag_read_i),
    .tag_way_i       (tag_way_i),
    .tag_full_i      (tag_full_i),
    .data_we_o       (data_we_o),
    .data_way_o      (data_way_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_rw_o    (mem_req_rw_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_ready_i     (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag array: hit way if present, otherwise the requested victim way.
  always_comb begin
    tag_way_i  = tag_way_o;
    tag_read_i = tag_mem[tag_way_o][tag_req_o.index];
    tag_full_i = 1'b1;
    for (int w = 0; w < WAYS; w++) begin
      if (!tag_mem[w][tag_req_o.index].valid) tag_full_i = 1'b0;
      if (tag_mem[w][tag_req_o.index].valid &&
          tag_mem[w][tag_req_o.index].tag == tag_addr_o[TAGMSB:TAGLSB]) begin
        tag_read_i = tag_mem[w][tag_req_o.index];
        tag_way_i  = INDEX_WAY'(w);
      end
    end
  end

  // Writes update the matching way, otherwise the selected victim way.
  always @(posedge clk) begin
    if (tag_req_o.we) begin
      if (tag_read_i.valid && tag_read_i.tag == tag_addr_o[TAGMSB:TAGLSB])
        tag_mem[tag_way_i][tag_req_o.index] <= tag_write_o;
      else
        tag_mem[tag_way_o][tag_req_o.index] <= tag_write_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One memory-request state: lat stalled cycles, then a ready cycle.
  task automatic mem_phase(input string nm, input logic rw, input logic [31:0] addr,
                           input int lat, input logic [1:0] way);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < lat; i++) begin
      cpu_req_valid = 1'b1;
      #1;
      chk({nm, ":stall_valid"}, 32'(mem_req_valid_o), 32'd1);
      chk({nm, ":stall_rw"}, 32'(mem_req_rw_o), 32'(rw));
      chk({nm, ":stall_addr"}, mem_req_addr_o, addr);
      chk({nm, ":stall_ready"}, 32'(cpu_req_ready_o), 32'd0);
      @(negedge clk);
      #1;
    end
    cpu_req_valid = 1'b0;
    mem_ready     = 1'b1;
    #1;
    chk({nm, ":valid"}, 32'(mem_req_valid_o), 32'd1);
    chk({nm, ":rw"}, 32'(mem_req_rw_o), 32'(rw));
    chk({nm, ":addr"}, mem_req_addr_o, addr);
    if (!rw) begin
      chk({nm, ":victim"}, 32'(tag_way_o), 32'(way));
      chk({nm, ":data_way"}, 32'(data_way_o), 32'(way));
      chk({nm, ":data_we"}, 32'(data_we_o), 32'd1);
      chk({nm, ":tag_we"}, 32'(tag_req_o.we), 32'd1);
      chk({nm, ":tag_wr"}, 32'(tag_write_o), 32'({2'b10, addr[31:14]}));
    end
  endtask

  task automatic access(input string nm, input logic rw, input logic [31:0] addr,
                        input bit hit, input bit wb, input logic [31:0] wb_addr,
                        input int wb_lat, input int rf_lat, input logic [1:0] way);
    logic [31:0] rf_addr;
    rf_addr = {addr[31:4], 4'b0};
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_rw    = rw;
    cpu_req_addr  = addr;
    #1;
    chk({nm, ":accept"}, 32'(cpu_req_ready_o), 32'd1);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    #1;
    if (hit) begin
      chk({nm, ":res"}, 32'(cpu_res_valid_o), 32'd1);
      chk({nm, ":no_mem"}, 32'(mem_req_valid_o), 32'd0);
      chk({nm, ":way"}, 32'(data_way_o), 32'(way));
      chk({nm, ":data_we"}, 32'(data_we_o), 32'(rw));
      chk({nm, ":tag_we"}, 32'(tag_req_o.we), 32'(rw));
    end else begin
      chk({nm, ":miss_res"}, 32'(cpu_res_valid_o), 32'd0);
      if (wb) mem_phase({nm, ":wb"}, 1'b1, wb_addr, wb_lat, way);
      mem_phase({nm, ":rf"}, 1'b0, rf_addr, rf_lat, way);
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk({nm, ":res"}, 32'(cpu_res_valid_o), 32'd1);
      chk({nm, ":hit_way"}, 32'(data_way_o), 32'(way));
    end
    @(negedge clk);
    #1;
    chk({nm, ":idle"}, 32'(cpu_req_ready_o), 32'd1);
    chk({nm, ":res_once"}, 32'(cpu_res_valid_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_rw    = 1'b0;
    cpu_req_addr  = '0;
    mem_ready     = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst:ready", 32'(cpu_req_ready_o), 32'd1);
    chk("rst:res", 32'(cpu_res_valid_o), 32'd0);
    chk("rst:mem_valid", 32'(mem_req_valid_o), 32'd0);
    chk("rst:tag_we", 32'(tag_req_o.we), 32'd0);
    chk("rst:data_we", 32'(data_we_o), 32'd0);
    chk("rst:tag_addr", tag_addr_o, 32'd0);
    chk("rst:mem_addr", mem_req_addr_o, 32'd0);
    chk("rst:ways", 32'({tag_way_o, data_way_o}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold miss, load hit, store hit on set 0x123.
    access("cold", 1'b0, 32'h0000_1230, 1'b0, 1'b0, '0, 0, 3, 2'd0);
    chk("cold:tag_entry", 32'(tag_mem[0][10'h123]), 32'h0008_0000);
    access("ld_hit", 1'b0, 32'h0000_1230, 1'b1, 1'b0, '0, 0, 0, 2'd0);
    access("st_hit", 1'b1, 32'h0000_1234, 1'b1, 1'b0, '0, 0, 0, 2'd0);
    chk("st_hit:dirty", 32'(tag_mem[0][10'h123]), 32'h000C_0000);

    // Fill ways 1..3, then evict the dirty line in way 0.
    access("fill1", 1'b0, 32'h0000_5230, 1'b0, 1'b0, '0, 0, 1, 2'd1);
    access("fill2", 1'b0, 32'h0000_9230, 1'b0, 1'b0, '0, 0, 1, 2'd2);
    access("fill3", 1'b0, 32'h0000_D230, 1'b0, 1'b0, '0, 0, 1, 2'd3);
    access("evict", 1'b0, 32'h0001_1230, 1'b0, 1'b1, 32'h0000_1230, 2, 1, 2'd0);
    chk("evict:tag_entry", 32'(tag_mem[0][10'h123]), 32'h0008_0004);

    // Round-robin wrap on set 0x200 with zero-latency memory.
    access("wrap0", 1'b0, 32'h0000_2000, 1'b0, 1'b0, '0, 0, 0, 2'd0);
    access("wrap1", 1'b0, 32'h0000_6000, 1'b0, 1'b0, '0, 0, 0, 2'd1);
    access("wrap2", 1'b0, 32'h0000_A000, 1'b0, 1'b0, '0, 0, 0, 2'd2);
    access("wrap3", 1'b0, 32'h0000_E000, 1'b0, 1'b0, '0, 0, 0, 2'd3);
    access("wrap4", 1'b0, 32'h0001_2000, 1'b0, 1'b0, '0, 0, 0, 2'd0);
    access("wrap5", 1'b0, 32'h0001_6000, 1'b0, 1'b0, '0, 0, 0, 2'd1);

    // Slow memory with CPU requests pending.
    access("stall", 1'b0, 32'h0000_3000, 1'b0, 1'b0, '0, 0, 20, 2'd0);

    // Reset while a refill is outstanding.
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_rw    = 1'b0;
    cpu_req_addr  = 32'h0000_0550;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rstmid:pre_valid", 32'(mem_req_valid_o), 32'd1);
    chk("rstmid:pre_addr", mem_req_addr_o, 32'h0000_0550);
    rst_n = 1'b0;
    #1;
    chk("rstmid:valid", 32'(mem_req_valid_o), 32'd0);
    chk("rstmid:ready", 32'(cpu_req_ready_o), 32'd1);
    chk("rstmid:mem_addr", mem_req_addr_o, 32'd0);
    chk("rstmid:tag_addr", tag_addr_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Victim pointers cleared: both sets refill into way 0 again.
    access("post_123", 1'b0, 32'h0001_5230, 1'b0, 1'b0, '0, 0, 1, 2'd0);
    access("post_200", 1'b0, 32'h0001_A000, 1'b0, 1'b0, '0, 0, 0, 2'd0);
    access("post_hit", 1'b0, 32'h0001_A00C, 1'b1, 1'b0, '0, 0, 0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
